dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data_memory port (WE, A, WD, RD) between the core load/store path (port C)
//  and a DMA/debug requester (port D). Core has priority; DMA gets multi-beat bursts with bounded
//  latency for both sides via wait counters. Sits between core/DMA and data_memory.
//  Drives core stall (c_gnt low) when the memory is lent to DMA.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  C_MAX_WAIT  4   core wait cycles before an active DMA burst is preempted (>=1)
//  D_MAX_WAIT  16  DMA wait cycles before DMA wins one beat over core (>=1)
//  WCNT_W      5   wait counter width; must hold max(C_MAX_WAIT, D_MAX_WAIT)
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   asynchronous, active-low reset
//  c_req     in   1   core access request (held until c_gnt)
//  c_we      in   1   core write enable
//  c_addr    in   AW  core address
//  c_wdata   in   DW  core write data
//  c_gnt     out  1   core beat accepted this cycle; low = core stalls
//  c_rdata   out  DW  read data, valid when c_gnt & ~c_we (combinational from mem_rd)
//  d_req     in   1   DMA beat request
//  d_we      in   1   DMA write enable
//  d_addr    in   AW  DMA address
//  d_wdata   in   DW  DMA write data
//  d_last    in   1   final beat of DMA burst
//  d_gnt     out  1   DMA beat accepted this cycle
//  d_rdata   out  DW  registered read data of last accepted DMA read beat
//  d_rvalid  out  1   d_rdata valid (one cycle after the granted read beat)
//  mem_we    out  1   to data_memory WE
//  mem_a     out  AW  to data_memory A
//  mem_wd    out  DW  to data_memory WD
//  mem_rd    in   DW  from data_memory RD (combinational read)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, counters=0, d_rdata=0, d_rvalid=0; grants/mem_we low while in reset.
//  - States: IDLE, CORE, DMA. Grant computed combinationally from state and requests; exactly one
//    grant per cycle max; mem_* muxed from granted port, mem_we=gnt&we; no grant -> mem_we=0, mem_a=0.
//  - IDLE/CORE: c_req -> c_gnt, state CORE; else d_req -> d_gnt, state DMA (or IDLE if d_last).
//    Exception: d_wait==D_MAX_WAIT and d_req -> DMA granted one beat over core (starvation guard).
//  - DMA: d_req -> d_gnt; d_gnt&d_last -> IDLE. If c_req held while in DMA, c_wait increments;
//    at c_wait==C_MAX_WAIT core granted next cycle, DMA burst suspended (state CORE), resumes
//    when core idle. Bubble (no d_req) in DMA: core granted immediately, no lock held.
//  - c_wait/d_wait: increment each cycle own req pending and not granted; clear on own grant; saturate.
//  - Simultaneous c_req&d_req in IDLE with d_wait<D_MAX_WAIT: core wins.
//  - d_rvalid/d_rdata: registered on d_gnt&~d_we, 1-cycle latency; d_rvalid low otherwise.
//  - Reset mid-burst: burst dropped, no memory write after rst falls; DMA must restart.
//  - Write then read same address on consecutive grants returns new data (memory write-first edge).
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs stat_c_beats, stat_d_beats, stat_conflicts (32 b each,
//    reset 0, wrap): granted beats per port; cycles with c_req&d_req. Undefined: ports and
//    logic absent; arbitration identical.
// TESTING
//  1 Reset: rst=0 -> all grants, mem_we, d_rvalid = 0; release, no requests -> mem_we stays 0.
//  2 Core only: c_req,c_we=1,addr 3,wdata 5; then read addr 3 -> c_gnt each cycle, c_rdata=5.
//  3 DMA burst: 4 writes addr 0..3 data 2..5, d_last on beat 4 -> d_gnt 4 cycles, state IDLE after;
//    DMA reads back -> d_rvalid one cycle later with 2,3,4,5.
//  4 Preempt: DMA 10-beat burst, core req at beat 2 -> core granted after exactly C_MAX_WAIT=4 waits,
//    DMA resumes next cycle, all 10 beats land in memory.
//  5 Starvation: c_req held continuously, d_req -> DMA granted at 17th cycle (D_MAX_WAIT=16), once.
//  6 Reset mid-burst at beat 3 -> no further mem_we; post-reset core access granted immediately;
//    with DMEM_ARB_STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core port has priority, DMA gets bursts, both sides have bounded waits.
// Optional statistics outputs are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int C_MAX_WAIT = 4,
    parameter int D_MAX_WAIT = 16,
    parameter int WCNT_W     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_last,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]   stat_c_beats,
    output logic [31:0]   stat_d_beats,
    output logic [31:0]   stat_conflicts,
`endif
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

    localparam logic [WCNT_W-1:0] C_MAX    = WCNT_W'(C_MAX_WAIT);
    localparam logic [WCNT_W-1:0] D_MAX    = WCNT_W'(D_MAX_WAIT);
    localparam logic [WCNT_W-1:0] WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [WCNT_W-1:0]   c_wait_r;
    logic [WCNT_W-1:0]   d_wait_r;
    logic                c_gnt_s;
    logic                d_gnt_s;
    logic                c_due_s;
    logic                d_due_s;
    logic [DW-1:0]       d_rdata_r;
    logic                d_rvalid_r;

    // Grant selection and next-state decision
    always_comb begin
        c_gnt_s     = 1'b0;
        d_gnt_s     = 1'b0;
        state_nxt_s = state_r;
        c_due_s     = c_req && (c_wait_r == C_MAX);
        d_due_s     = d_req && (d_wait_r == D_MAX);
        case (state_r)
            ST_DMA: begin
                // Burst holds the port unless the core has waited its limit or the burst bubbles
                if (c_due_s) begin
                    c_gnt_s = 1'b1;
                end else if (d_req) begin
                    d_gnt_s = 1'b1;
                end else if (c_req) begin
                    c_gnt_s = 1'b1;
                end else begin
                    c_gnt_s = 1'b0;
                end
            end
            ST_IDLE, ST_CORE: begin
                if (d_due_s) begin
                    d_gnt_s = 1'b1;
                end else if (c_req) begin
                    c_gnt_s = 1'b1;
                end else if (d_req) begin
                    d_gnt_s = 1'b1;
                end else begin
                    d_gnt_s = 1'b0;
                end
            end
            default: begin
                c_gnt_s = 1'b0;
                d_gnt_s = 1'b0;
            end
        endcase
        if (!rst) begin
            c_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else begin
            c_gnt_s = c_gnt_s;
        end
        if (c_gnt_s) begin
            state_nxt_s = ST_CORE;
        end else if (d_gnt_s) begin
            // A starvation beat taken over a waiting core does not lock the port for DMA
            if (d_last) begin
                state_nxt_s = ST_IDLE;
            end else if ((state_r != ST_DMA) && c_req) begin
                state_nxt_s = ST_CORE;
            end else begin
                state_nxt_s = ST_DMA;
            end
        end else if (state_r == ST_CORE) begin
            state_nxt_s = ST_IDLE;
        end else if (state_r == ST_DMA) begin
            state_nxt_s = ST_DMA;
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // Memory port mux from the granted requester
    always_comb begin
        mem_we = 1'b0;
        mem_a  = {AW{1'b0}};
        mem_wd = {DW{1'b0}};
        if (c_gnt_s) begin
            mem_we = c_we;
            mem_a  = c_addr;
            mem_wd = c_wdata;
        end else if (d_gnt_s) begin
            mem_we = d_we;
            mem_a  = d_addr;
            mem_wd = d_wdata;
        end else begin
            mem_we = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Saturating wait counters; a dropped request also clears its counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_wait_r <= {WCNT_W{1'b0}};
            d_wait_r <= {WCNT_W{1'b0}};
        end else begin
            if (c_gnt_s || !c_req) begin
                c_wait_r <= {WCNT_W{1'b0}};
            end else if (c_wait_r != C_MAX) begin
                c_wait_r <= c_wait_r + WCNT_ONE;
            end else begin
                c_wait_r <= c_wait_r;
            end
            if (d_gnt_s || !d_req) begin
                d_wait_r <= {WCNT_W{1'b0}};
            end else if (d_wait_r != D_MAX) begin
                d_wait_r <= d_wait_r + WCNT_ONE;
            end else begin
                d_wait_r <= d_wait_r;
            end
        end
    end

    // DMA read-data capture, one cycle after the granted read beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_rvalid_r <= 1'b0;
            d_rdata_r  <= {DW{1'b0}};
        end else begin
            d_rvalid_r <= d_gnt_s & ~d_we;
            if (d_gnt_s && !d_we) begin
                d_rdata_r <= mem_rd;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_c_r;
    logic [31:0] stat_d_r;
    logic [31:0] stat_x_r;

    // Wrapping beat and conflict counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_c_r <= 32'd0;
            stat_d_r <= 32'd0;
            stat_x_r <= 32'd0;
        end else begin
            stat_c_r <= stat_c_r + {31'd0, c_gnt_s};
            stat_d_r <= stat_d_r + {31'd0, d_gnt_s};
            stat_x_r <= stat_x_r + {31'd0, c_req & d_req};
        end
    end

    assign stat_c_beats   = stat_c_r;
    assign stat_d_beats   = stat_d_r;
    assign stat_conflicts = stat_x_r;
`endif

    assign c_gnt    = c_gnt_s;
    assign d_gnt    = d_gnt_s;
    assign c_rdata  = mem_rd;
    assign d_rdata  = d_rdata_r;
    assign d_rvalid = d_rvalid_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small behavioural data memory and read scoreboard.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_gnt;
    logic [DW-1:0] c_rdata;
    logic          d_req = 1'b0, d_we = 1'b0, d_last = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]   stat_c_beats, stat_d_beats, stat_conflicts;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int d_beats_done = 0;
    logic [DW-1:0] dq[$];
    logic [DW-1:0] cq[$];
    logic [DW-1:0] tb_mem [0:31];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_last(d_last),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
`ifdef DMEM_ARB_STATS_EN
        .stat_c_beats(stat_c_beats), .stat_d_beats(stat_d_beats), .stat_conflicts(stat_conflicts),
`endif
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Data memory: combinational read, write on the rising edge
    assign mem_rd = tb_mem[mem_a[4:0]];
    always @(posedge clk) if (mem_we) tb_mem[mem_a[4:0]] <= mem_wd;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle monitor: reset behaviour, single grant, DMA read latency and data scoreboard
    logic exp_rvalid = 1'b0;
    logic rst_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("rst_c_gnt", 64'(c_gnt), 64'd0);
            check_eq("rst_d_gnt", 64'(d_gnt), 64'd0);
            check_eq("rst_mem_we", 64'(mem_we), 64'd0);
            check_eq("rst_d_rvalid", 64'(d_rvalid), 64'd0);
        end else if (rst_prev) begin
            check_eq("one_gnt", 64'(c_gnt & d_gnt), 64'd0);
            if (!c_gnt && !d_gnt) check_eq("nognt_we", 64'(mem_we), 64'd0);
            if (d_rvalid || exp_rvalid) check_eq("d_rvalid", 64'(d_rvalid), 64'(exp_rvalid));
            if (d_rvalid) begin
                if (dq.size() == 0) check_eq("dq_pending", 64'(dq.size()), 64'd1);
                else check_eq("d_rdata", 64'(d_rdata), 64'(dq.pop_front()));
            end
        end
        exp_rvalid = rst && d_gnt && !d_we;
        rst_prev = rst;
    end

    task automatic core_access(input logic we, input logic [4:0] addr, input logic [DW-1:0] wdata,
                               input logic [DW-1:0] exp_rd, output int waits);
        bit got;
        c_req = 1'b1; c_we = we; c_addr = AW'(addr); c_wdata = wdata;
        if (!we) cq.push_back(exp_rd);
        waits = 0; got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (c_gnt) begin got = 1'b1; break; end
            waits++;
        end
        if (!got) check_eq("c_timeout", 64'(c_gnt), 64'd1);
        else if (!we) check_eq("c_rdata", 64'(c_rdata), 64'(cq.pop_front()));
        tick();
        c_req = 1'b0;
    endtask

    task automatic dma_beat(input logic we, input logic [4:0] addr, input logic [DW-1:0] wdata,
                            input logic last, input logic [DW-1:0] exp_rd, output int waits);
        bit got;
        d_req = 1'b1; d_we = we; d_addr = AW'(addr); d_wdata = wdata; d_last = last;
        if (!we) dq.push_back(exp_rd);
        waits = 0; got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (d_gnt) begin got = 1'b1; break; end
            waits++;
        end
        if (!got) check_eq("d_timeout", 64'(d_gnt), 64'd1);
        tick();
        d_beats_done++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt;
        for (int i = 0; i < 32; i++) tb_mem[i] = '0;

        // 1: reset with requests pending, then quiet after release
        c_req = 1'b1; c_we = 1'b1; d_req = 1'b1; d_we = 1'b1;
        repeat (3) @(negedge clk);
        tick();
        c_req = 1'b0; d_req = 1'b0; rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("t1_idle_we", 64'(mem_we), 64'd0);
        end
        tick();

        // 2: core write then read of the same address
        core_access(1'b1, 5'd3, 32'd5, 32'd0, w);
        check_eq("t2_wr_wait", 64'(w), 64'd0);
        core_access(1'b0, 5'd3, 32'd0, 32'd5, w);
        check_eq("t2_rd_wait", 64'(w), 64'd0);

        // 3: DMA write burst, then core vs DMA read contention, then DMA read-back
        for (int i = 0; i < 4; i++) begin
            dma_beat(1'b1, 5'(i), DW'(i + 2), i == 3, 32'd0, w);
            check_eq("t3_wr_wait", 64'(w), 64'd0);
        end
        d_req = 1'b0;
        fork
            begin
                int cw;
                core_access(1'b0, 5'd2, 32'd0, 32'd4, cw);
                check_eq("t3_core_first", 64'(cw), 64'd0);
            end
            begin
                int dw;
                for (int i = 0; i < 4; i++) begin
                    dma_beat(1'b0, 5'(i), 32'd0, i == 3, DW'(i + 2), dw);
                    check_eq("t3_rd_wait", 64'(dw), (i == 0) ? 64'd1 : 64'd0);
                end
                d_req = 1'b0;
            end
        join
        repeat (2) tick();
        check_eq("t3_dq_drained", 64'(dq.size()), 64'd0);

        // 4: core preempts a 10-beat DMA burst after C_MAX_WAIT waits
        d_beats_done = 0;
        fork
            begin
                int dw;
                for (int i = 0; i < 10; i++) dma_beat(1'b1, 5'(4 + i), DW'(32'h100 + i), i == 9, 32'd0, dw);
                d_req = 1'b0;
            end
            begin
                int cw;
                wait (d_beats_done == 1);
                core_access(1'b1, 5'd20, 32'h77, 32'd0, cw);
                check_eq("t4_core_waits", 64'(cw), 64'd4);
                @(negedge clk);
                check_eq("t4_dma_resume", 64'(d_gnt), 64'd1);
            end
        join
        tick();
        for (int i = 0; i < 10; i++) check_eq("t4_mem", 64'(tb_mem[4 + i]), 64'(32'h100 + i));
        check_eq("t4_core_mem", 64'(tb_mem[20]), 64'h77);

        // 5: starvation guard under a continuously requesting core
        c_req = 1'b1; c_we = 1'b1; c_addr = AW'(31); c_wdata = 32'hC0DE;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = AW'(30); d_wdata = 32'hAB; d_last = 1'b1;
        w = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_gnt) break;
            w++;
        end
        check_eq("t5_waits", 64'(w), 64'd16);
        tick();
        d_addr = AW'(29); d_wdata = 32'hCD;
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            cnt += int'(d_gnt);
        end
        check_eq("t5_once", 64'(cnt), 64'd0);
        @(negedge clk);
        check_eq("t5_second", 64'(d_gnt), 64'd1);
        tick();
        c_req = 1'b0; d_req = 1'b0;
        tick();
        check_eq("t5_mem30", 64'(tb_mem[30]), 64'hAB);
        check_eq("t5_mem29", 64'(tb_mem[29]), 64'hCD);

        // 6: reset in the middle of a DMA write burst
        dma_beat(1'b1, 5'd24, 32'h60, 1'b0, 32'd0, w);
        dma_beat(1'b1, 5'd25, 32'h61, 1'b0, 32'd0, w);
        d_addr = AW'(26); d_wdata = 32'h62;
        c_req = 1'b1; c_we = 1'b1; c_addr = AW'(27); c_wdata = 32'h55;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("t6_rst_we", 64'(mem_we), 64'd0);
        end
`ifdef DMEM_ARB_STATS_EN
        check_eq("t6_stat_c", 64'(stat_c_beats), 64'd0);
        check_eq("t6_stat_d", 64'(stat_d_beats), 64'd0);
        check_eq("t6_stat_x", 64'(stat_conflicts), 64'd0);
`endif
        tick();
        c_req = 1'b0; d_req = 1'b0; rst = 1'b1;
        core_access(1'b1, 5'd27, 32'h99, 32'd0, w);
        check_eq("t6_core_wait", 64'(w), 64'd0);
        tick();
        check_eq("t6_mem24", 64'(tb_mem[24]), 64'h60);
        check_eq("t6_mem25", 64'(tb_mem[25]), 64'h61);
        check_eq("t6_mem26", 64'(tb_mem[26]), 64'h0);
        check_eq("t6_mem27", 64'(tb_mem[27]), 64'h99);
        check_eq("dq_end", 64'(dq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
